pipe_fetch: RTL and testbench

PIPE_FETCH -- requirements
Module: pipe_fetch

---
 rtl/pipe_fetch.sv | 71 +++++++
 tb/tb_pipe_fetch.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch.sv
// pipe_fetch: instruction fetch stage with single-word hold buffer and pending-redirect capture
module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] ins,
    output logic        fvalid
);
    typedef enum logic {FETCH, HOLD} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ptarget_q, ptarget_d, hold_q, hold_d, sel_pc, next_pc;
    logic        pend_q, pend_d, fetch, xfer;
    // outputs, target selection and next-state: a delivered word always transfers before any redirect applies
    always_comb begin
        fetch     = state_q == FETCH;
        imem_req  = !reset && fetch;
        imem_addr = pc_q;
        pc        = pc_q;
        pc4       = pc_q + 32'd4;
        fvalid    = !reset && (fetch ? imem_ready : 1'b1);
        ins       = !fvalid ? 32'h0 : fetch ? imem_rdata : hold_q;
        sel_pc    = pcsource == 2'b01 ? bpc : pcsource == 2'b10 ? rpc : pcsource == 2'b11 ? jpc : pc4;
        sel_pc[1:0] = 2'b00;
        next_pc   = pend_q ? ptarget_q : sel_pc;
        xfer      = fvalid && wpcir;
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        ptarget_d = ptarget_q;
        hold_d    = hold_q;
        if (xfer) begin
            pc_d    = next_pc;
            state_d = FETCH;
            pend_d  = 1'b0;
        end else if (fetch && imem_ready && !wpcir) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
        end else if (fetch && !imem_ready && wpcir && pcsource != 2'b00 && !pend_q) begin
            pend_d    = 1'b1;
            ptarget_d = sel_pc;
        end
    end
    // state registers with synchronous reset that also abandons any outstanding request
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            ptarget_q <= 32'h0;
            hold_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            ptarget_q <= ptarget_d;
            hold_q    <= hold_d;
        end
    end
endmodule

// File: tb/tb_pipe_fetch.sv
// tb_pipe_fetch: directed scenario tests for pipe_fetch
module tb_pipe_fetch;
    logic        clock = 1'b0, reset = 1'b1, wpcir = 1'b0, imem_ready = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0, rpc = 32'h0, jpc = 32'h0, imem_rdata = 32'h0;
    logic        imem_req, fvalid, imem_req_b, fvalid_b;
    logic [31:0] imem_addr, pc, pc4, ins, imem_addr_b, pc_b, pc4_b, ins_b;
    int passed = 0, total = 0;

    always #5 clock = ~clock;

    pipe_fetch dut (
        .clock(clock), .reset(reset), .wpcir(wpcir), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc), .pc4(pc4),
        .ins(ins), .fvalid(fvalid)
    );

    pipe_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clock(clock), .reset(reset), .wpcir(wpcir), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc_b), .pc4(pc4_b),
        .ins(ins_b), .fvalid(fvalid_b)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [31:0] rdata, input logic w, input logic [1:0] src);
        imem_ready = rdy;
        imem_rdata = rdata;
        wpcir      = w;
        pcsource   = src;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 2'b00);
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b1, 32'h1234_5678, 1'b1, 2'b00);
        total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req); else passed++;
        total++; if (fvalid !== 1'b0) $display("FAIL rst_fvalid got %b exp 0", fvalid); else passed++;
        total++; if (ins !== 32'h0) $display("FAIL rst_ins got %h exp 00000000", ins); else passed++;
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 2'b00);
        total++; if (pc !== 32'h0) $display("FAIL rst_pc got %h exp 00000000", pc); else passed++;
        total++; if (pc4 !== 32'h4) $display("FAIL rst_pc4 got %h exp 00000004", pc4); else passed++;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rst_first_req got %b/%h exp 1/00000000", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_sequential;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1000 + i, 1'b1, 2'b00);
            total++; if (imem_addr !== 32'(4 * i) || pc !== 32'(4 * i)) $display("FAIL seq_addr%0d got %h/%h exp %h", i, imem_addr, pc, 4 * i); else passed++;
            total++; if (fvalid !== 1'b1 || ins !== 32'h1000 + i) $display("FAIL seq_ins%0d got %b/%h exp 1/%h", i, fvalid, ins, 32'h1000 + i); else passed++;
            tick();
        end
    endtask

    task automatic test_delayed;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'hDEAD_0000, 1'b1, 2'b00);
            total++; if (fvalid !== 1'b0 || ins !== 32'h0) $display("FAIL dly_bubble%0d got %b/%h exp 0/00000000", i, fvalid, ins); else passed++;
            total++; if (pc !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1) $display("FAIL dly_pc%0d got %h/%h/%b exp 0/0/1", i, pc, imem_addr, imem_req); else passed++;
            tick();
        end
        drive(1'b1, 32'hAAAA_5555, 1'b1, 2'b00);
        total++; if (fvalid !== 1'b1 || ins !== 32'hAAAA_5555) $display("FAIL dly_word got %b/%h exp 1/aaaa5555", fvalid, ins); else passed++;
        total++; if (pc4 !== 32'h4) $display("FAIL dly_pc4 got %h exp 00000004", pc4); else passed++;
        tick();
        total++; if (pc !== 32'h4) $display("FAIL dly_next got %h exp 00000004", pc); else passed++;
    endtask

    task automatic test_hold;
        do_reset();
        drive(1'b1, 32'h0, 1'b1, 2'b00);
        tick();
        tick();
        drive(1'b1, 32'h0000_BEEF, 1'b0, 2'b00);
        total++; if (pc !== 32'h8 || fvalid !== 1'b1) $display("FAIL hold_arrive got %h/%b exp 00000008/1", pc, fvalid); else passed++;
        tick();
        bpc = 32'h300;
        drive(1'b0, 32'hDEAD_DEAD, 1'b0, 2'b01);
        total++; if (imem_req !== 1'b0) $display("FAIL hold_req got %b exp 0", imem_req); else passed++;
        total++; if (ins !== 32'h0000_BEEF || fvalid !== 1'b1 || pc !== 32'h8) $display("FAIL hold_ins got %h/%b/%h exp 0000beef/1/00000008", ins, fvalid, pc); else passed++;
        tick();
        total++; if (ins !== 32'h0000_BEEF || pc !== 32'h8) $display("FAIL hold_stable got %h/%h exp 0000beef/00000008", ins, pc); else passed++;
        drive(1'b0, 32'hDEAD_DEAD, 1'b1, 2'b00);
        tick();
        total++; if (imem_addr !== 32'hC || imem_req !== 1'b1) $display("FAIL hold_next got %h/%b exp 0000000c/1", imem_addr, imem_req); else passed++;
    endtask

    task automatic test_branch;
        do_reset();
        jpc = 32'h100;
        drive(1'b1, 32'h0, 1'b1, 2'b11);
        tick();
        total++; if (pc !== 32'h100) $display("FAIL br_jump got %h exp 00000100", pc); else passed++;
        bpc = 32'h203;
        drive(1'b1, 32'h1111_2222, 1'b1, 2'b01);
        total++; if (ins !== 32'h1111_2222) $display("FAIL br_delay_slot got %h exp 11112222", ins); else passed++;
        tick();
        total++; if (imem_addr !== 32'h200) $display("FAIL br_target got %h exp 00000200", imem_addr); else passed++;
    endtask

    task automatic test_redirect;
        do_reset();
        jpc = 32'h104;
        drive(1'b1, 32'h0, 1'b1, 2'b11);
        tick();
        jpc = 32'h400;
        drive(1'b0, 32'h0, 1'b1, 2'b11);
        total++; if (fvalid !== 1'b0 || ins !== 32'h0) $display("FAIL rd_bubble got %b/%h exp 0/00000000", fvalid, ins); else passed++;
        tick();
        jpc = 32'h700;
        bpc = 32'h800;
        total++; if (pc !== 32'h104 || imem_addr !== 32'h104) $display("FAIL rd_pc_hold got %h/%h exp 00000104", pc, imem_addr); else passed++;
        drive(1'b0, 32'h0, 1'b1, 2'b01);
        tick();
        rpc = 32'h900;
        drive(1'b1, 32'h5555_0104, 1'b1, 2'b10);
        total++; if (fvalid !== 1'b1 || ins !== 32'h5555_0104 || pc !== 32'h104) $display("FAIL rd_delivered got %b/%h/%h exp 1/55550104/00000104", fvalid, ins, pc); else passed++;
        tick();
        total++; if (imem_addr !== 32'h400) $display("FAIL rd_target got %h exp 00000400", imem_addr); else passed++;
        drive(1'b1, 32'h0, 1'b1, 2'b00);
        tick();
        total++; if (imem_addr !== 32'h404) $display("FAIL rd_pend_clear got %h exp 00000404", imem_addr); else passed++;
    endtask

    task automatic test_wrap;
        reset = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 2'b00);
        total++; if (imem_req_b !== 1'b0) $display("FAIL wr_rst_req got %b exp 0", imem_req_b); else passed++;
        tick();
        reset = 1'b0;
        drive(1'b1, 32'h0, 1'b1, 2'b00);
        total++; if (imem_addr_b !== 32'hFFFF_FFFC || pc4_b !== 32'h0) $display("FAIL wr_pc4 got %h/%h exp fffffffc/00000000", imem_addr_b, pc4_b); else passed++;
        tick();
        total++; if (imem_addr_b !== 32'h0) $display("FAIL wr_after got %h exp 00000000", imem_addr_b); else passed++;
        tick();
        drive(1'b0, 32'h0, 1'b1, 2'b00);
        tick();
        total++; if (imem_req_b !== 1'b1 || imem_addr_b !== 32'h4) $display("FAIL wr_wait got %b/%h exp 1/00000004", imem_req_b, imem_addr_b); else passed++;
        reset = 1'b1;
        #1;
        total++; if (imem_req_b !== 1'b0 || fvalid_b !== 1'b0) $display("FAIL wr_midrst got %b/%b exp 0/0", imem_req_b, fvalid_b); else passed++;
        tick();
        reset = 1'b0;
        #1;
        total++; if (imem_req_b !== 1'b1 || imem_addr_b !== 32'hFFFF_FFFC || pc_b !== 32'hFFFF_FFFC) $display("FAIL wr_restart got %b/%h exp 1/fffffffc", imem_req_b, imem_addr_b); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_delayed();
        test_hold();
        test_branch();
        test_redirect();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
